seq_detect_scheduler: RTL and testbench



---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_detect_scheduler_if.sv | 27 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/seq_detect_scheduler.sv | 99 +++++++++
 tb/tb_seq_detect_scheduler.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - state encoding and next-state helpers for the shared "11" detector
package seq_det_pkg;

    localparam logic [1:0] ST_ZERO  = 2'd0;
    localparam logic [1:0] ST_ONE1  = 2'd1;
    localparam logic [1:0] ST_TWO1S = 2'd2;

    // Moore "11" detector transition; the unused code 3 recovers to ZERO
    function automatic logic [1:0] seq_det_next(input logic [1:0] state, input logic in_bit);
        logic [1:0] nxt;
        case (state)
            ST_ZERO:  nxt = in_bit ? ST_ONE1  : ST_ZERO;
            ST_ONE1:  nxt = in_bit ? ST_TWO1S : ST_ZERO;
            ST_TWO1S: nxt = in_bit ? ST_TWO1S : ST_ZERO;
            default:  nxt = ST_ZERO;
        endcase
        return nxt;
    endfunction

    function automatic logic seq_det_hit(input logic [1:0] state);
        return state == ST_TWO1S;
    endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// rtl/seq_detect_scheduler_if.sv - channel request and detection report bundle
interface seq_detect_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_clear;
    logic              det_valid;
    logic [CH_W-1:0]   det_ch;
    logic [1:0]        det_state;
    logic [CNT_W-1:0]  det_count;

    // serial sources and event consumer side
    modport master (
        output ch_valid, ch_bit, ch_clear,
        input  ch_ready, det_valid, det_ch, det_state, det_count
    );

    // scheduler side
    modport slave (
        input  ch_valid, ch_bit, ch_clear,
        output ch_ready, det_valid, det_ch, det_state, det_count
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting after the last winner
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_any
);
    logic [CH_W-1:0] cand;

    // scan ptr+1, ptr+2, ... wrapping; the first requester wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - one "11" detector time-shared across NUM_CH serial streams
module seq_detect_scheduler
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detect_scheduler_if.slave bus
);
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [NUM_CH-1:0] grant;
    logic              grant_any;
    logic [1:0]        acc_state;
    logic [1:0]        ch_state      [NUM_CH];
    logic [1:0]        ch_state_next [NUM_CH];
    logic              det_valid_q;
    logic [CH_W-1:0]   det_ch_q;
    logic [1:0]        det_state_q;
    logic [CNT_W-1:0]  det_count_q;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (bus.ch_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.ch_ready  = grant;
    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.det_state = det_state_q;
    assign bus.det_count = det_count_q;

    // new state of the granted channel; a clear on that channel overrides the bit
    always_comb begin
        acc_state = seq_det_next(ch_state[grant_idx], bus.ch_bit[grant_idx]);
        if (bus.ch_clear[grant_idx]) begin
            acc_state = ST_ZERO;
        end
    end

    // only the granted channel and cleared channels move; all others hold
    always_comb begin
        for (int j = 0; j < NUM_CH; j++) begin
            ch_state_next[j] = ch_state[j];
            if (grant_any && grant[j]) begin
                ch_state_next[j] = acc_state;
            end
            if (bus.ch_clear[j]) begin
                ch_state_next[j] = ST_ZERO;
            end
        end
    end

    // per-channel detector state storage
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_CH; j++) begin
            if (reset) begin
                ch_state[j] <= ST_ZERO;
            end else begin
                ch_state[j] <= ch_state_next[j];
            end
        end
    end

    // pointer and detection report; report fields hold between transfers, the pulse does not
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= CH_W'(NUM_CH - 1);
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_state_q <= ST_ZERO;
        end else if (grant_any) begin
            rr_ptr      <= grant_idx;
            det_valid_q <= seq_det_hit(acc_state);
            det_ch_q    <= grant_idx;
            det_state_q <= acc_state;
        end else begin
            det_valid_q <= 1'b0;
        end
    end

    // saturating count of detection pulses, advancing on the edge that raises det_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            det_count_q <= '0;
        end else if (grant_any && seq_det_hit(acc_state) && (det_count_q != '1)) begin
            det_count_q <= det_count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - randomized and directed bench for seq_detect_scheduler
module tb_seq_detect_scheduler;
    localparam int N        = 4;
    localparam int CW       = 2;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk;
    logic reset;

    seq_detect_scheduler_if #(.NUM_CH(N), .CH_W(CW), .CNT_W(TB_CNT_W)) bus ();

    seq_detect_scheduler #(
        .NUM_CH (N),
        .CH_W   (CW),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // reference: each channel remembers how many consecutive 1s it has accepted
    int          m_run [N];
    int          m_ptr;
    logic        m_dv;
    logic [CW-1:0] m_dch;
    logic [1:0]  m_dst;
    int          m_cnt;
    logic [N-1:0] exp_ready;
    logic [N-1:0] obs_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic model_reset();
        for (int j = 0; j < N; j++) m_run[j] = 0;
        m_ptr = N - 1;
        m_dv  = 1'b0;
        m_dch = '0;
        m_dst = 2'd0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clear = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // one cycle: drive, capture ch_ready mid-cycle, advance the model, settle after the edge
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] b, input logic [N-1:0] c);
        logic          found;
        logic [CW-1:0] g;
        logic [CW-1:0] ci;
        bus.ch_valid = v;
        bus.ch_bit   = b;
        bus.ch_clear = c;
        @(negedge clk);
        obs_ready = bus.ch_ready;
        found = 1'b0;
        g     = '0;
        for (int k = 1; k <= N; k++) begin
            ci = CW'((m_ptr + k) % N);
            if (!found && v[ci]) begin
                found = 1'b1;
                g     = ci;
            end
        end
        exp_ready = '0;
        if (found) begin
            exp_ready[g] = 1'b1;
            m_run[g] = b[g] ? m_run[g] + 1 : 0;
        end
        for (int j = 0; j < N; j++) if (c[j]) m_run[j] = 0;
        if (found) begin
            m_dch = g;
            m_dst = (m_run[g] >= 2) ? 2'd2 : 2'(m_run[g]);
            m_dv  = (m_dst == 2'd2);
            m_ptr = int'(g);
            if (m_dv && m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_dv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (bus.det_valid !== 1'b0) $display("FAIL reset_det_valid got %b want 0", bus.det_valid); else pass_cnt++;
        total_cnt++; if (bus.det_ch !== 2'd0) $display("FAIL reset_det_ch got %0d want 0", bus.det_ch); else pass_cnt++;
        total_cnt++; if (bus.det_state !== 2'd0) $display("FAIL reset_det_state got %0d want 0", bus.det_state); else pass_cnt++;
        total_cnt++; if (bus.det_count !== 4'd0) $display("FAIL reset_det_count got %0d want 0", bus.det_count); else pass_cnt++;
        total_cnt++; if (bus.ch_ready !== 4'b0000) $display("FAIL reset_ready_idle got %b want 0000", bus.ch_ready); else pass_cnt++;
        bus.ch_valid = 4'b1111;
        #1;
        total_cnt++; if (bus.ch_ready !== 4'b0001) $display("FAIL reset_first_grant got %b want 0001", bus.ch_ready); else pass_cnt++;
        bus.ch_valid = '0;
    endtask

    task automatic test_single_stream();
        logic [3:0] bits;
        logic [3:0] want_dv;
        logic [1:0] want_st [4];
        bits    = 4'b0111;
        want_dv = 4'b0110;
        want_st = '{2'd1, 2'd2, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, {3'b000, bits[i]}, 4'b0000);
            total_cnt++; if (bus.det_valid !== want_dv[i]) $display("FAIL single_dv[%0d] got %b want %b", i, bus.det_valid, want_dv[i]); else pass_cnt++;
            total_cnt++; if (bus.det_state !== want_st[i]) $display("FAIL single_state[%0d] got %0d want %0d", i, bus.det_state, want_st[i]); else pass_cnt++;
        end
        total_cnt++; if (bus.det_count !== 4'd2) $display("FAIL single_count got %0d want 2", bus.det_count); else pass_cnt++;
        drive(4'b0000, 4'b0000, 4'b0000);
        total_cnt++; if (bus.det_valid !== 1'b0 || bus.det_state !== 2'd0) $display("FAIL single_idle_hold dv=%b st=%0d want 0/0", bus.det_valid, bus.det_state); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 4'($urandom), 4'b0000);
            want = 4'b0001 << (i % 4);
            total_cnt++; if (obs_ready !== want) $display("FAIL rr_ready[%0d] got %b want %b", i, obs_ready, want); else pass_cnt++;
            total_cnt++; if (bus.det_ch !== m_dch || bus.det_state !== m_dst || bus.det_valid !== m_dv)
                $display("FAIL rr_report[%0d] got ch=%0d st=%0d dv=%b want ch=%0d st=%0d dv=%b", i, bus.det_ch, bus.det_state, bus.det_valid, m_dch, m_dst, m_dv);
            else pass_cnt++;
        end
    endtask

    task automatic test_interleave();
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0000);
        drive(4'b0010, 4'b0000, 4'b0000);
        drive(4'b0001, 4'b0001, 4'b0000);
        total_cnt++; if (bus.det_valid !== 1'b1 || bus.det_ch !== 2'd0) $display("FAIL interleave_hit got dv=%b ch=%0d want 1/0", bus.det_valid, bus.det_ch); else pass_cnt++;
        drive(4'b0010, 4'b0010, 4'b0000);
        total_cnt++; if (bus.det_valid !== 1'b0 || bus.det_state !== 2'd1 || bus.det_ch !== 2'd1)
            $display("FAIL interleave_ch1 got dv=%b st=%0d ch=%0d want 0/1/1", bus.det_valid, bus.det_state, bus.det_ch);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        do_reset();
        drive(4'b0100, 4'b0100, 4'b0000);
        drive(4'b0100, 4'b0100, 4'b0100);
        total_cnt++; if (bus.det_valid !== 1'b0 || bus.det_state !== 2'd0 || bus.det_ch !== 2'd2)
            $display("FAIL clear_same_cycle got dv=%b st=%0d ch=%0d want 0/0/2", bus.det_valid, bus.det_state, bus.det_ch);
        else pass_cnt++;
        drive(4'b0100, 4'b0100, 4'b0000);
        total_cnt++; if (bus.det_valid !== 1'b0 || bus.det_state !== 2'd1) $display("FAIL clear_after got dv=%b st=%0d want 0/1", bus.det_valid, bus.det_state); else pass_cnt++;
        drive(4'b1000, 4'b1000, 4'b0000);
        drive(4'b0001, 4'b0000, 4'b1000);
        drive(4'b1000, 4'b1000, 4'b0000);
        total_cnt++; if (bus.det_state !== 2'd1 || bus.det_valid !== 1'b0) $display("FAIL clear_other got st=%0d dv=%b want 1/0", bus.det_state, bus.det_valid); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(4'b0001, 4'b0001, 4'b0000);
            total_cnt++; if (bus.det_count !== TB_CNT_W'(m_cnt)) $display("FAIL sat_count[%0d] got %0d want %0d", i, bus.det_count, m_cnt); else pass_cnt++;
        end
        total_cnt++; if (bus.det_count !== 4'd15) $display("FAIL sat_final got %0d want 15", bus.det_count); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [N-1:0] c;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v = 4'($urandom);
            for (int j = 0; j < N; j++) c[j] = ($urandom_range(0, 7) == 0);
            drive(v, 4'($urandom), c);
            total_cnt++; if (obs_ready !== exp_ready) $display("FAIL rand_ready[%0d] got %b want %b", i, obs_ready, exp_ready); else pass_cnt++;
            total_cnt++; if (bus.det_valid !== m_dv || bus.det_ch !== m_dch || bus.det_state !== m_dst || bus.det_count !== TB_CNT_W'(m_cnt))
                $display("FAIL rand_report[%0d] got dv=%b ch=%0d st=%0d cnt=%0d want dv=%b ch=%0d st=%0d cnt=%0d",
                         i, bus.det_valid, bus.det_ch, bus.det_state, bus.det_count, m_dv, m_dch, m_dst, m_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'b0010, 4'b0010, 4'b0000);
        drive(4'b0010, 4'b0010, 4'b0000);
        total_cnt++; if (bus.det_valid !== 1'b1 || bus.det_ch !== 2'd1) $display("FAIL mid_setup got dv=%b ch=%0d want 1/1", bus.det_valid, bus.det_ch); else pass_cnt++;
        reset        = 1'b1;
        bus.ch_valid = 4'b1111;
        bus.ch_bit   = 4'b1111;
        bus.ch_clear = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        total_cnt++; if (bus.det_valid !== 1'b0 || bus.det_ch !== 2'd0 || bus.det_state !== 2'd0 || bus.det_count !== 4'd0)
            $display("FAIL mid_reset got dv=%b ch=%0d st=%0d cnt=%0d want all 0", bus.det_valid, bus.det_ch, bus.det_state, bus.det_count);
        else pass_cnt++;
        drive(4'b1111, 4'b0000, 4'b0000);
        total_cnt++; if (obs_ready !== 4'b0001) $display("FAIL mid_first_grant got %b want 0001", obs_ready); else pass_cnt++;
        drive(4'b0010, 4'b0010, 4'b0000);
        total_cnt++; if (bus.det_state !== 2'd1 || bus.det_valid !== 1'b0) $display("FAIL mid_ch1_cleared got st=%0d dv=%b want 1/0", bus.det_state, bus.det_valid); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clear = '0;
        model_reset();
        test_reset();
        test_single_stream();
        test_round_robin();
        test_interleave();
        test_clear();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
